led8: RTL and testbench
=======================

# led8

Eight-LED rotating "running light" controller for the board's LED bank, clocked from the 100 MHz system clock. A single lit LED rotates left or right at one of four selectable step rates. A push-button toggles between running and paused. The block sits directly between the board's switch/button inputs and the LED pins.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- DIV0, CLK_HZ/1000, clock cycles per step when freq_set=00 (1000 Hz).
- DIV1, CLK_HZ/100, clock cycles per step when freq_set=01 (100 Hz).
- DIV2, CLK_HZ/20, clock cycles per step when freq_set=10 (20 Hz).
- DIV3, CLK_HZ/5, clock cycles per step when freq_set=11 (5 Hz).
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- button  input  1  start/stop request; asynchronous to clk; level-high press.
- freq_set  input  2  step-rate select, as listed under Parameters.
- dir_set  input  1  direction: 1 = rotate left (toward led[7]), 0 = rotate right.
- led  output  8  LED drive, one-hot, 1 = lit.

## Operation
- Reset state:
  - led = 8'b0000_0001.
  - running = 0.
  - Divider counter = 0.
  - Button synchronizer and edge-detect registers = 0.
- Button handling:
  - button passes through a 2-FF synchronizer, then a rising-edge detector.
  - Each detected rising edge toggles running.
  - Holding the button high counts as a single press.
  - No additional debounce is applied.
- Divider, while running:
  - The counter increments every cycle.
  - When counter >= DIVsel-1, a step strobe fires and the counter returns to 0.
  - DIVsel is the divisor selected by the current freq_set.
- Divider, while paused:
  - The counter is held at 0.
  - led holds its value; the pattern is preserved across pause and resume.
- Step behaviour:
  - dir_set=1: led <= {led[6:0], led[7]}.
  - dir_set=0: led <= {led[0], led[7:1]}.
  - Rotation wraps, so the one-hot pattern is always preserved.
- freq_set and dir_set are sampled live with no synchronizer; they are quasi-static switches.
  - A dir_set change takes effect at the next step.
  - A freq_set change takes effect immediately on the comparison.
  - Switching to a shorter period while counter >= new DIVsel-1 causes a step on the next cycle.

## Timing
- Press latency: button rising edge → running toggles 3 clk edges later (2 synchronizer stages + 1 edge register).
- First step after resume occurs DIVsel cycles after running becomes 1.
- Steady-state step period:
  - exactly DIVsel cycles.
  - At 100 MHz: 100 000 / 1 000 000 / 5 000 000 / 20 000 000 cycles.
- Step strobe and led update occur on the same edge; led is a registered output with no combinational path from the inputs.
- Asynchronous reset asserted mid-operation returns all state to the reset values immediately. Normal operation restarts on the first clk edge after deassertion, in the paused state.
- Minimum button high pulse: 1 clk period.
- Minimum button low time between presses: 1 clk period.
- Counter width: ceil(log2(max DIV)) = 25 bits for the defaults.

## Structure
- Shared package holds:
  - CLK_HZ.
  - The four step-rate constants.
  - The freq_set encoding constants (FREQ_1KHZ=2'b00, FREQ_100HZ=2'b01, FREQ_20HZ=2'b10, FREQ_5HZ=2'b11).
  - The direction encoding constants (DIR_LEFT=1, DIR_RIGHT=0).
- One sub-module: led8_tick_gen.
  - Contains the divisor mux, counter, and step strobe.
  - Inputs: clk, rst, enable, freq_set. Output: tick.
- The top level holds the button synchronizer/edge detector, the running flag, and the rotating register.

## Test plan
- Reset:
  - Hold rst low for 5 cycles → led=8'h01 and running=0.
  - Release, wait 1 ms → led still 8'h01.
- Start, 1 kHz, left:
  - freq_set=00, dir_set=1, 2-cycle button pulse → led=8'h02 after 100 003 cycles, 8'h04 after a further 100 000.
  - After 10 ms, 10 steps total; led wraps through 8'h80 → 8'h01.
- Pause/resume:
  - A second press freezes led for 2 ms with no change.
  - A third press resumes from the frozen value; next step occurs 100 000 cycles later.
- Direction:
  - dir_set=0 while running → subsequent steps halve led, with wrap 8'h01 → 8'h80.
  - dir_set=1 restores left rotation.
- Rates:
  - freq_set=01/10/11 → measured step periods of 1 000 000 / 5 000 000 / 20 000 000 cycles.
  - Switching from 11 to 00 mid-count produces a step on the next cycle.
- Async reset mid-run:
  - rst pulsed low for 2 cycles between clock edges → led=8'h01 immediately and running=0.
  - No steps occur afterwards until a new press.

Source files
------------

// File: rtl/led8_pkg.sv
// rtl/led8_pkg.sv - shared constants and types for the led8 running-light controller
package led8_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Clock cycles per rotation step for each freq_set code
  localparam int unsigned DIV0 = CLK_HZ / 1000;
  localparam int unsigned DIV1 = CLK_HZ / 100;
  localparam int unsigned DIV2 = CLK_HZ / 20;
  localparam int unsigned DIV3 = CLK_HZ / 5;

  localparam logic [1:0] FREQ_1KHZ  = 2'b00;
  localparam logic [1:0] FREQ_100HZ = 2'b01;
  localparam logic [1:0] FREQ_20HZ  = 2'b10;
  localparam logic [1:0] FREQ_5HZ   = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width that holds 0 .. max_div-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned max_div);
    return (max_div > 1) ? $clog2(max_div) : 1;
  endfunction

endpackage

// File: rtl/led8_tick_gen.sv
// rtl/led8_tick_gen.sv - selectable-rate step strobe for the led8 rotator
module led8_tick_gen
  import led8_pkg::*;
#(
  parameter int unsigned DIV0 = led8_pkg::DIV0,
  parameter int unsigned DIV1 = led8_pkg::DIV1,
  parameter int unsigned DIV2 = led8_pkg::DIV2,
  parameter int unsigned DIV3 = led8_pkg::DIV3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] freq_set,
  output logic       tick
);

  localparam int unsigned CNT_W = cnt_width(max4(DIV0, DIV1, DIV2, DIV3));

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] div_m1;

  always_comb begin
    div_m1 = CNT_W'(DIV0 - 1);
    case (freq_set)
      FREQ_1KHZ:  div_m1 = CNT_W'(DIV0 - 1);
      FREQ_100HZ: div_m1 = CNT_W'(DIV1 - 1);
      FREQ_20HZ:  div_m1 = CNT_W'(DIV2 - 1);
      FREQ_5HZ:   div_m1 = CNT_W'(DIV3 - 1);
      default:    div_m1 = CNT_W'(DIV0 - 1);
    endcase
  end

  // >= rather than == so a switch to a shorter period never skips past the terminal count
  assign tick = enable && (count >= div_m1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led8.sv
// rtl/led8.sv - eight-LED rotating running light with start/stop button
module led8
  import led8_pkg::*;
#(
  parameter int unsigned DIV0 = led8_pkg::DIV0,
  parameter int unsigned DIV1 = led8_pkg::DIV1,
  parameter int unsigned DIV2 = led8_pkg::DIV2,
  parameter int unsigned DIV3 = led8_pkg::DIV3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [1:0] freq_set,
  input  logic       dir_set,
  output logic [7:0] led
);

  logic       btn_sync1;
  logic       btn_sync2;
  logic       btn_prev;
  logic       press;
  logic       running;
  logic       tick;
  run_state_t state_q;
  run_state_t state_d;

  // Two-stage synchronizer followed by a rising-edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_prev  <= 1'b0;
    end else begin
      btn_sync1 <= button;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
    end
  end

  assign press = btn_sync2 && !btn_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED:  if (press) state_d = ST_RUNNING;
      ST_RUNNING: if (press) state_d = ST_PAUSED;
      default:    state_d = ST_PAUSED;
    endcase
  end

  assign running = (state_q == ST_RUNNING);

  led8_tick_gen #(
    .DIV0(DIV0),
    .DIV1(DIV1),
    .DIV2(DIV2),
    .DIV3(DIV3)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (running),
    .freq_set (freq_set),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= 8'b0000_0001;
    end else if (tick) begin
      if (dir_set == DIR_LEFT) begin
        led <= {led[6:0], led[7]};
      end else begin
        led <= {led[0], led[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_led8.sv
// tb/tb_led8.sv - directed self-checking bench for led8 with shortened step divisors
module tb_led8;

  localparam int unsigned T_DIV0 = 10;
  localparam int unsigned T_DIV1 = 20;
  localparam int unsigned T_DIV2 = 40;
  localparam int unsigned T_DIV3 = 80;

  logic       clk;
  logic       rst;
  logic       button;
  logic [1:0] freq_set;
  logic       dir_set;
  logic [7:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  led8 #(
    .DIV0(T_DIV0),
    .DIV1(T_DIV1),
    .DIV2(T_DIV2),
    .DIV3(T_DIV3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .freq_set (freq_set),
    .dir_set  (dir_set),
    .led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    button   = 1'b0;
    freq_set = 2'b00;
    dir_set  = 1'b1;

    cycles(5);
    check("reset_led", 32'(led), 32'h01);
    check("reset_running", 32'(dut.running), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycles(30);
    check("idle_led", 32'(led), 32'h01);

    // Start: running toggles on edge 3, first step on edge 3 + DIV0
    @(negedge clk);
    button = 1'b1;
    cycles(2);
    button = 1'b0;
    cycles(10);
    check("start_running", 32'(dut.running), 32'h1);
    check("start_pre_step", 32'(led), 32'h01);
    cycles(1);
    check("start_step1", 32'(led), 32'h02);
    cycles(9);
    check("start_pre_step2", 32'(led), 32'h02);
    cycles(1);
    check("start_step2", 32'(led), 32'h04);
    cycles(60);
    check("left_wrap_8steps", 32'(led), 32'h01);
    cycles(20);
    check("left_10steps", 32'(led), 32'h04);

    // Pause
    button = 1'b1;
    cycles(1);
    button = 1'b0;
    cycles(50);
    check("pause_running", 32'(dut.running), 32'h0);
    check("pause_frozen", 32'(led), 32'h04);

    // Resume from frozen value
    button = 1'b1;
    cycles(1);
    button = 1'b0;
    cycles(11);
    check("resume_pre_step", 32'(led), 32'h04);
    cycles(1);
    check("resume_step", 32'(led), 32'h08);

    // Right rotation with wrap
    dir_set = 1'b0;
    cycles(10);
    check("right_step1", 32'(led), 32'h04);
    cycles(20);
    check("right_step3", 32'(led), 32'h01);
    cycles(10);
    check("right_wrap", 32'(led), 32'h80);
    dir_set = 1'b1;
    cycles(10);
    check("left_again_wrap", 32'(led), 32'h01);

    // Rate selection
    freq_set = 2'b01;
    cycles(19);
    check("rate01_pre", 32'(led), 32'h01);
    cycles(1);
    check("rate01_step", 32'(led), 32'h02);
    freq_set = 2'b10;
    cycles(39);
    check("rate10_pre", 32'(led), 32'h02);
    cycles(1);
    check("rate10_step", 32'(led), 32'h04);
    freq_set = 2'b11;
    cycles(79);
    check("rate11_pre", 32'(led), 32'h04);
    cycles(1);
    check("rate11_step", 32'(led), 32'h08);

    // Shorter period mid-count: counter already past DIV0-1
    cycles(30);
    check("midcount_pre", 32'(led), 32'h08);
    freq_set = 2'b00;
    cycles(1);
    check("midcount_step", 32'(led), 32'h10);
    cycles(10);
    check("midcount_next", 32'(led), 32'h20);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h01);
    check("async_running", 32'(dut.running), 32'h0);
    cycles(2);
    #3;
    rst = 1'b1;
    cycles(50);
    check("post_reset_led", 32'(led), 32'h01);
    check("post_reset_running", 32'(dut.running), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
